// File: rtl/dda_column_writer.sv
// Expands one DDA hit record per screen column into SCREEN_HEIGHT framebuffer writes (ceiling, wall, floor); tlast flips the back buffer.
// First write strobe the cycle after accept, one column per SCREEN_HEIGHT+1 cycles; fb_wready low holds the pending write and the row counter.
module dda_column_writer #(
    parameter int         SCREEN_WIDTH  = 320,
    parameter int         SCREEN_HEIGHT = 180,
    parameter logic [7:0] CEIL_CODE     = 8'h00,
    parameter logic [7:0] FLOOR_CODE    = 8'h01,
    localparam int        AW            = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic          dda_out_tvalid,
    input  logic [37:0]   dda_out_tdata,
    input  logic          dda_out_tlast,
    output logic          dda_out_tready,
    input  logic          fb_wready,
    output logic          fb_we_out,
    output logic [AW-1:0] fb_addr_out,
    output logic [7:0]    fb_data_out,
    output logic          fb_buf_out,
    output logic          frame_done_out,
    output logic [7:0]    drop_count_out
);

    typedef struct packed {
        logic [8:0]  hcount;
        logic [7:0]  line_height;
        logic        wall_type;
        logic [3:0]  map_data;
        logic [15:0] wall_x;
    } hit_t;

    typedef enum logic [1:0] {IDLE, DRAW, SWAP} state_t;

    localparam logic signed [10:0] MID      = 11'(SCREEN_HEIGHT / 2);
    localparam logic signed [10:0] ROW_MAX  = 11'(SCREEN_HEIGHT - 1);
    localparam logic [AW-1:0]      ROW_STEP = AW'(SCREEN_WIDTH);
    localparam logic [9:0]         COL_LIM  = 10'(SCREEN_WIDTH);
    localparam logic [7:0]         LAST_ROW = 8'(SCREEN_HEIGHT - 1);

    state_t            state, state_next;
    hit_t              rec;
    logic              ready_en;
    logic [7:0]        vcount;
    logic signed [10:0] draw_start, draw_end;
    logic              wall_type_q;
    logic [3:0]        map_data_q;
    logic              tlast_q;

    logic signed [10:0] half, start_raw, end_raw, start_c, end_c;
    logic              accept, in_range, write_taken, last_row;
    logic              unused_wall_x;

    assign rec           = dda_out_tdata;
    assign unused_wall_x = ^rec.wall_x;

    function automatic logic [7:0] pixel_code(input logic [7:0] v,
                                              input logic signed [10:0] s,
                                              input logic signed [10:0] e,
                                              input logic wt,
                                              input logic [3:0] md);
        logic signed [10:0] vs;
        vs = $signed({3'b000, v});
        if (vs < s)
            return CEIL_CODE;
        else if (vs > e)
            return FLOOR_CODE;
        else
            return {3'b001, wt, md};
    endfunction

    // Wall span for the incoming record, clamped to the visible rows.
    always_comb begin
        half      = $signed({3'b000, rec.line_height}) >>> 1;
        start_raw = MID - half;
        end_raw   = MID + half - 11'sd1;
        start_c   = start_raw[10] ? 11'sd0 : start_raw;
        end_c     = (end_raw > ROW_MAX) ? ROW_MAX : end_raw;
    end

    assign accept      = dda_out_tvalid && dda_out_tready;
    assign in_range    = {1'b0, rec.hcount} < COL_LIM;
    assign write_taken = fb_we_out && fb_wready;
    assign last_row    = (vcount == LAST_ROW);

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        dda_out_tready = (state == IDLE) && ready_en;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_range)
                        state_next = DRAW;
                    else if (dda_out_tlast)
                        state_next = SWAP;
                end
            end
            DRAW: begin
                if (write_taken && last_row)
                    state_next = tlast_q ? SWAP : IDLE;
            end
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            ready_en       <= 1'b0;
            vcount         <= '0;
            draw_start     <= '0;
            draw_end       <= '0;
            wall_type_q    <= 1'b0;
            map_data_q     <= '0;
            tlast_q        <= 1'b0;
            fb_we_out      <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= '0;
            fb_buf_out     <= 1'b0;
            frame_done_out <= 1'b0;
            drop_count_out <= '0;
        end else begin
            ready_en <= 1'b1;
            // The flip lands on the edge entering SWAP, so the pulse spans the SWAP cycle.
            frame_done_out <= (state_next == SWAP);
            if (state_next == SWAP)
                fb_buf_out <= ~fb_buf_out;

            if (accept) begin
                draw_start  <= start_c;
                draw_end    <= end_c;
                wall_type_q <= rec.wall_type;
                map_data_q  <= rec.map_data;
                tlast_q     <= dda_out_tlast;
                if (in_range) begin
                    vcount      <= '0;
                    fb_we_out   <= 1'b1;
                    fb_addr_out <= AW'(rec.hcount);
                    fb_data_out <= pixel_code(8'd0, start_c, end_c, rec.wall_type, rec.map_data);
                end else if (drop_count_out != 8'hFF) begin
                    drop_count_out <= drop_count_out + 8'd1;
                end
            end

            if (write_taken) begin
                if (last_row) begin
                    fb_we_out <= 1'b0;
                end else begin
                    vcount      <= vcount + 8'd1;
                    fb_addr_out <= fb_addr_out + ROW_STEP;
                    fb_data_out <= pixel_code(vcount + 8'd1, draw_start, draw_end,
                                              wall_type_q, map_data_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_dda_column_writer.sv
// Directed bench for dda_column_writer: column contents, clamping, stalls, frame flips, drops and reset.
module tb_dda_column_writer;

    localparam int W = 320;
    localparam int H = 180;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        dda_out_tvalid = 1'b0;
    logic [37:0] dda_out_tdata = '0;
    logic        dda_out_tlast = 1'b0;
    logic        dda_out_tready;
    logic        fb_wready = 1'b1;
    logic        fb_we_out;
    logic [15:0] fb_addr_out;
    logic [7:0]  fb_data_out;
    logic        fb_buf_out;
    logic        frame_done_out;
    logic [7:0]  drop_count_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc      = 0;
    bit bp_en    = 1'b0;

    logic [15:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int          wr_total = 0;
    logic [15:0] last_addr = '0;
    int          last_wr_cyc = 0;
    int          fd_count = 0;
    int          fd_cyc = 0;
    int          stab_err = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    dda_column_writer dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_in         (rst_in),
        .dda_out_tvalid (dda_out_tvalid),
        .dda_out_tdata  (dda_out_tdata),
        .dda_out_tlast  (dda_out_tlast),
        .dda_out_tready (dda_out_tready),
        .fb_wready      (fb_wready),
        .fb_we_out      (fb_we_out),
        .fb_addr_out    (fb_addr_out),
        .fb_data_out    (fb_data_out),
        .fb_buf_out     (fb_buf_out),
        .frame_done_out (frame_done_out),
        .drop_count_out (drop_count_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    always @(negedge pixel_clk_in)
        fb_wready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

    // Edge-accurate record of taken writes, frame pulses and stall stability.
    always @(posedge pixel_clk_in) begin
        if (fb_we_out === 1'b1 && fb_wready === 1'b1) begin
            wq_addr.push_back(fb_addr_out);
            wq_data.push_back(fb_data_out);
            wr_total    = wr_total + 1;
            last_addr   = fb_addr_out;
            last_wr_cyc = cyc;
        end
        if (frame_done_out === 1'b1) begin
            fd_count = fd_count + 1;
            fd_cyc   = cyc;
        end
        if (prev_stall && (fb_we_out !== 1'b1 || fb_addr_out !== prev_addr || fb_data_out !== prev_data))
            stab_err = stab_err + 1;
        prev_stall = (fb_we_out === 1'b1) && (fb_wready === 1'b0);
        prev_addr  = fb_addr_out;
        prev_data  = fb_data_out;
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] px(input int i);
        if (i < wq_data.size())
            return wq_data[i];
        return 8'hxx;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input int hc, input int lh, input int wt, input int md, input bit tl);
        int n;
        n = 0;
        dda_out_tdata  = {9'(hc), 8'(lh), 1'(wt), 4'(md), 16'hBEEF};
        dda_out_tlast  = tl;
        dda_out_tvalid = 1'b1;
        while (dda_out_tready !== 1'b1 && n < 1000) begin
            @(negedge pixel_clk_in);
            n++;
        end
        if (n >= 1000)
            chk("send_timeout", n, 0);
        @(negedge pixel_clk_in);
        acc = cyc - 1;
        dda_out_tvalid = 1'b0;
        dda_out_tlast  = 1'b0;
    endtask

    // Latency is counted from the accepting edge to the first cycle with tready high.
    task automatic wait_ready(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (dda_out_tready !== 1'b1 && n < 5000) begin
            @(negedge pixel_clk_in);
            n++;
        end
        chk(tag, cyc - acc, exp_lat);
    endtask

    task automatic check_col(input string tag, input int base, input int hc,
                             input int ws, input int we, input logic [7:0] code);
        int bad;
        bad = 0;
        chk({tag, "_nwr"}, wq_addr.size() - base, H);
        for (int v = 0; v < H; v++) begin
            logic [7:0] ed;
            ed = (v < ws) ? 8'h00 : ((v > we) ? 8'h01 : code);
            if (base + v >= wq_addr.size())
                bad++;
            else if (wq_addr[base + v] !== 16'(hc + v * W) || wq_data[base + v] !== ed)
                bad++;
        end
        chk({tag, "_pix"}, bad, 0);
    endtask

    initial begin
        int b, t0, f0, s0;
        #1 rst_in = 1'b1;
        repeat (3) @(negedge pixel_clk_in);
        chk("rst_tready", dda_out_tready, 0);
        chk("rst_we", fb_we_out, 0);
        chk("rst_addr", fb_addr_out, 0);
        chk("rst_data", fb_data_out, 0);
        chk("rst_buf", fb_buf_out, 0);
        chk("rst_fd", frame_done_out, 0);
        chk("rst_drop", drop_count_out, 0);
        rst_in = 1'b0;
        chk("rel_tready_pre", dda_out_tready, 0);
        @(negedge pixel_clk_in);
        chk("rel_tready", dda_out_tready, 1);

        // Basic column: wall rows 40..139, code {001,1,0011}
        b = wq_addr.size();
        send(5, 100, 1, 3, 1'b0);
        chk("basic_first_we", fb_we_out, 1);
        chk("basic_first_addr", fb_addr_out, 5);
        chk("basic_tready_busy", dda_out_tready, 0);
        wait_ready("basic_lat", 181);
        check_col("basic", b, 5, 40, 139, 8'h33);
        chk("basic_v39", px(b + 39), 8'h00);
        chk("basic_v40", px(b + 40), 8'h33);
        chk("basic_v139", px(b + 139), 8'h33);
        chk("basic_v140", px(b + 140), 8'h01);
        chk("basic_we_off", fb_we_out, 0);

        // Clamping and empty span
        b = wq_addr.size();
        send(319, 255, 0, 10, 1'b0);
        wait_ready("lh255_lat", 181);
        check_col("lh255", b, 319, 0, 179, 8'h2A);
        b = wq_addr.size();
        send(0, 0, 1, 0, 1'b0);
        wait_ready("lh0_lat", 181);
        check_col("lh0", b, 0, 90, 89, 8'h30);
        chk("lh0_v89", px(b + 89), 8'h00);
        chk("lh0_v90", px(b + 90), 8'h01);
        b = wq_addr.size();
        send(7, 101, 1, 15, 1'b0);
        wait_ready("lh101_lat", 181);
        check_col("lh101", b, 7, 40, 139, 8'h3F);
        chk("lh101_v40", px(b + 40), 8'h3F);

        // Backpressure
        bp_en = 1'b1;
        s0 = stab_err;
        b = wq_addr.size();
        send(10, 100, 0, 5, 1'b0);
        begin
            int n;
            n = 0;
            while (dda_out_tready !== 1'b1 && n < 5000) begin
                @(negedge pixel_clk_in);
                n++;
            end
            chk("bp_stalled_longer", (cyc - acc) > 181, 1);
        end
        bp_en = 1'b0;
        check_col("bp", b, 10, 40, 139, 8'h25);
        chk("bp_stable", stab_err - s0, 0);

        // Full frame, tlast on column 319
        chk("frame_buf_before", fb_buf_out, 0);
        t0 = wr_total;
        f0 = fd_count;
        for (int h = 0; h < W; h++) begin
            send(h, 100, 0, 1, h == W - 1);
            wait_ready("frame_lat", (h == W - 1) ? 182 : 181);
        end
        chk("frame_writes", wr_total - t0, W * H);
        chk("frame_last_addr", last_addr, 57599);
        chk("frame_fd_count", fd_count - f0, 1);
        chk("frame_fd_timing", fd_cyc - last_wr_cyc, 1);
        chk("frame_fd_low", frame_done_out, 0);
        chk("frame_buf_after", fb_buf_out, 1);

        // Dropped tlast record still swaps
        t0 = wr_total;
        f0 = fd_count;
        send(400, 100, 0, 0, 1'b1);
        chk("drop_fd_now", frame_done_out, 1);
        wait_ready("drop_lat", 2);
        chk("drop_count1", drop_count_out, 1);
        chk("drop_buf", fb_buf_out, 0);
        chk("drop_fd_count", fd_count - f0, 1);
        chk("drop_fd_timing", fd_cyc, acc + 1);
        send(511, 50, 0, 0, 1'b1);
        wait_ready("drop2_lat", 2);
        chk("drop_count2", drop_count_out, 2);
        chk("drop2_buf", fb_buf_out, 1);
        chk("drop_no_writes", wr_total - t0, 0);

        // Asynchronous reset in the middle of a column
        send(20, 100, 1, 1, 1'b0);
        repeat (20) @(negedge pixel_clk_in);
        chk("mid_we", fb_we_out, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_we", fb_we_out, 0);
        chk("arst_buf", fb_buf_out, 0);
        chk("arst_addr", fb_addr_out, 0);
        t0 = wr_total;
        repeat (3) @(negedge pixel_clk_in);
        chk("arst_tready", dda_out_tready, 0);
        rst_in = 1'b0;
        chk("arst_rel_pre", dda_out_tready, 0);
        @(negedge pixel_clk_in);
        chk("arst_rel_tready", dda_out_tready, 1);
        chk("arst_drop", drop_count_out, 0);
        repeat (200) @(negedge pixel_clk_in);
        chk("arst_no_writes", wr_total - t0, 0);

        // Drop counter saturation, starting at hcount=320
        t0 = wr_total;
        for (int i = 0; i < 300; i++) begin
            send(320 + (i % 190), 10, 0, 0, 1'b0);
            if (i == 253)
                chk("sat_254", drop_count_out, 254);
            if (i == 254)
                chk("sat_255", drop_count_out, 255);
        end
        chk("sat_final", drop_count_out, 255);
        chk("sat_no_writes", wr_total - t0, 0);
        chk("sat_tready", dda_out_tready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, expected finish)");
        $fatal(1);
    end

endmodule
